// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction-memory read port plus the core-side handshake and redirect.
interface inst_fetch_if import fetch_pkg::*; #(parameter int IMEM_AW = 9);

  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        inst;
  logic [XLEN-1:0]    inst_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               fault;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, fault,
    input  imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, fault,
    output imem_rdata, inst_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst}; flush wins over push/pop, push+pop both apply.
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against flush and occupancy.
  always_comb begin
    do_push_s = push && !flush;
    do_pop_s  = pop && !flush && (count_r != {CW{1'b0}});
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_r + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CW{1'b0}});
  assign full  = (count_r == CW'(DEPTH));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetch PC, 1-cycle imem reads, buffered {inst, pc} to the core.
// FETCH_ALIGN_CHK_EN: misaligned redirects raise a sticky fault and halt fetch until reset.
module inst_fetch import fetch_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter int              IMEM_AW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_r;
  logic [XLEN-1:0] fetch_pc_r;
  logic            inflight_r;
  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            pop_s;
  logic            push_s;
  logic            issue_s;
  logic [CW:0]     occupancy_s;
  fetch_entry_t    head_s;
  fetch_entry_t    push_data_s;
  logic [CW-1:0]   count_s;
  logic            empty_s;
  logic            full_s;
`ifdef FETCH_ALIGN_CHK_EN
  logic            fault_r;
`endif

  // Issue credit counts buffered + in-flight words, crediting a same-cycle pop.
  always_comb begin
    redirect_s  = bus.redirect && (state_r != HALT);
`ifdef FETCH_ALIGN_CHK_EN
    target_s    = bus.redirect_pc;
`else
    target_s    = bus.redirect_pc & ~32'd3;
`endif
    pop_s       = !empty_s && bus.inst_ready;
    occupancy_s = {1'b0, count_s} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
    issue_s     = (state_r == RUN) && !redirect_s && (occupancy_s < (CW+1)'(FIFO_DEPTH));
    push_s      = inflight_r && !redirect_s && (!full_s || pop_s);
    push_data_s = '{pc: {XLEN{1'b0}}, inst: bus.imem_rdata};
    push_data_s.pc = fetch_pc_r - PC_STEP;
  end

  // FSM, fetch PC and in-flight tracking; a redirect kills the response arriving this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      inflight_r <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
      fault_r    <= 1'b0;
`endif
    end else begin
      inflight_r <= issue_s;
      case (state_r)
        IDLE, RUN: begin
          state_r <= RUN;
          if (redirect_s) begin
            fetch_pc_r <= target_s;
`ifdef FETCH_ALIGN_CHK_EN
            if (pc_misaligned(target_s)) begin
              state_r <= HALT;
              fault_r <= 1'b1;
            end
`endif
          end else if (issue_s) begin
            fetch_pc_r <= fetch_pc_r + PC_STEP;
          end
        end
        HALT:    state_r <= HALT;
        default: state_r <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (redirect_s),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  assign bus.imem_req   = issue_s;
  assign bus.imem_addr  = fetch_pc_r[IMEM_AW+1:2];
  assign bus.inst_valid = !empty_s;
  assign bus.inst       = empty_s ? NOP_INST : head_s.inst;
  assign bus.inst_pc    = empty_s ? {XLEN{1'b0}} : head_s.pc;
`ifdef FETCH_ALIGN_CHK_EN
  assign bus.fault      = fault_r;
`else
  assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: expected PC stream per redirect, checked on each transfer.
module tb_inst_fetch;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  inst_fetch_if #(.IMEM_AW(9)) bus ();
  inst_fetch_if #(.IMEM_AW(9)) bus2 ();

  inst_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .IMEM_AW(9)) dut (
    .clk(clk), .rst(rst), .bus(bus.master));
  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .IMEM_AW(9)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.master));

  // Instruction memory: word n holds 0x1000_0000+n, data only after a request.
  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_req  ? 32'h1000_0000 + {23'd0, bus.imem_addr}  : 32'hDEAD_BEEF;
    bus2.imem_rdata <= bus2.imem_req ? 32'h1000_0000 + {23'd0, bus2.imem_addr} : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000_0000 + {23'd0, pc[10:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, bus.imem_req},   32'd0);
    chk({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, "_inst"},  bus.inst,                NOP_INST);
    chk({tag, "_pc"},    bus.inst_pc,             32'd0);
    chk({tag, "_fault"}, {31'd0, bus.fault},      32'd0);
  endtask

  // Redirect for one cycle; the model restarts its stream at the word-aligned target.
  task automatic redirect_to(input logic [31:0] tgt);
    bus.redirect    = 1'b1;
    bus.redirect_pc = tgt;
    step();
    bus.redirect = 1'b0;
    load_stream(tgt & 32'hFFFF_FFFC);
  endtask

  // Reset, then release so the current cycle is the IDLE cycle.
  task automatic restart();
    rst = 1'b1;
    step();
    load_stream(32'h0);
    rst = 1'b0;
  endtask

  logic        held = 1'b0;
  logic [31:0] held_pc, held_inst;

  // Monitor: NOP when idle, stability under backpressure, scoreboard pop per transfer.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      held = 1'b0;
    end else begin
      if (!bus.inst_valid) begin
        chk("idle_inst", bus.inst, NOP_INST);
        chk("idle_pc", bus.inst_pc, 32'd0);
      end else begin
        if (held) begin
          chk("hold_pc", bus.inst_pc, held_pc);
          chk("hold_inst", bus.inst, held_inst);
        end
        if (bus.inst_ready) begin
          if (exp_q.size() == 0) begin
            chk("xfer_unexpected", bus.inst_pc, 32'hFFFF_FFFF);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("xfer_pc", bus.inst_pc, e);
            chk("xfer_inst", bus.inst, mem_word(e));
          end
        end
      end
`ifndef FETCH_ALIGN_CHK_EN
      chk("fault_tied", {31'd0, bus.fault}, 32'd0);
`endif
      held      = bus.inst_valid && !bus.inst_ready && !bus.redirect;
      held_pc   = bus.inst_pc;
      held_inst = bus.inst;
    end
  end

  initial begin
    bit found;
    int since;
    logic [31:0] tgt;
    bus.inst_ready   = 1'b0;
    bus.redirect     = 1'b0;
    bus.redirect_pc  = 32'd0;
    bus2.inst_ready  = 1'b1;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 32'd0;
    #1 rst = 1'b1;
    repeat (3) step();
    chk_reset_outputs("rst");

    // Startup latency, throughput and RESET_PC wrap on the second instance.
    load_stream(32'h0);
    mon_en = 1'b1;
    bus.inst_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("idle_cycle_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("c0_req", {31'd0, bus.imem_req}, 32'd1);
    chk("c0_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    chk("c1_valid", {31'd0, bus.inst_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stream_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("stream_pc", bus.inst_pc, 32'(4 * k));
      chk("wrap_valid", {31'd0, bus2.inst_valid}, 32'd1);
      chk("wrap_pc", bus2.inst_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("wrap_inst", bus2.inst, mem_word(32'hFFFF_FFF8 + 32'(4 * k)));
    end

    // Backpressure for 6 cycles: head held at pc 0x14, requests stop once buffered.
    step();
    bus.inst_ready = 1'b0;
    for (int s = 0; s < 6; s++) begin
      if (s > 0) step();
      chk("stall_pc", bus.inst_pc, 32'h14);
      chk("stall_inst", bus.inst, mem_word(32'h14));
      if (s > 0) chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.inst_ready = 1'b1;
    repeat (8) step();

    // Redirect while a response is in flight: it must be dropped.
    bus.inst_ready = 1'b0;
    restart();
    step();
    step();
    step();
    chk("pre_redir_pc", bus.inst_pc, 32'h0);
    redirect_to(32'h40);
    chk("redir_next_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    chk("redir_r2_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    chk("redir_r3_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("redir_r3_pc", bus.inst_pc, 32'h40);
    bus.inst_ready = 1'b1;
    repeat (4) step();

    // Redirect coinciding with the transfer of pc 0x10.
    redirect_to(32'h8);
    found = 1'b0;
    for (int w = 0; w < 10 && !found; w++) begin
      if (bus.inst_valid && bus.inst_pc == 32'h10) found = 1'b1;
      else step();
    end
    chk("found_0x10", {31'd0, found}, 32'd1);
    redirect_to(32'h80);
    chk("redir2_next_valid", {31'd0, bus.inst_valid}, 32'd0);
    step();
    step();
    chk("redir2_r3_pc", bus.inst_pc, 32'h80);

    // Misaligned redirect target.
    redirect_to(32'h42);
`ifdef FETCH_ALIGN_CHK_EN
    for (int h = 0; h < 5; h++) begin
      chk("halt_fault", {31'd0, bus.fault}, 32'd1);
      chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
      step();
    end
    restart();
`else
    step();
    step();
    chk("misalign_pc", bus.inst_pc, 32'h40);
    chk("misalign_fault", {31'd0, bus.fault}, 32'd0);
`endif

    // Randomized backpressure and redirects.
    since = 0;
    for (int c = 0; c < 800; c++) begin
      bus.inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0 || since > 100) begin
        tgt = $urandom;
`ifdef FETCH_ALIGN_CHK_EN
        tgt = tgt & 32'hFFFF_FFFC;
`endif
        redirect_to(tgt);
        since = 0;
      end else begin
        step();
        since++;
      end
    end

    // Reset mid-stream, checked between clock edges.
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    bus.inst_ready = 1'b1;
    step();
    load_stream(32'h0);
    rst = 1'b0;
    step();
    step();
    step();
    chk("post_rst_pc", bus.inst_pc, 32'h0);
    repeat (10) step();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
